// File: rtl/fault_campaign_seq_pkg.sv
// Shared types and constants for the fault-injection campaign sequencer.
// Covers the fault-type encoding that the injector sees, the campaign FSM states and the sweep sizes.
package fault_campaign_seq_pkg;

  localparam int N_LOC      = 8;
  localparam int N_FTYPE    = 3;
  localparam int N_INJ      = N_LOC * N_FTYPE;
  localparam int MUL_CYCLES = 4;
  localparam int MOD_CYCLES = 8;

  typedef enum logic [1:0] {
    FT_NONE = 2'b00,
    FT_SA0  = 2'b01,
    FT_SA1  = 2'b10,
    FT_FLIP = 2'b11
  } fault_type_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    MOD,
    INJ,
    CMP,
    DONE
  } camp_state_e;

  // Bits [4:3] of the sweep index count completed location sweeps (0..2).
  // Adding 1 to that count gives the fault type for the current sweep.
  function automatic fault_type_e ftype_of(logic [4:0] idx);
    return fault_type_e'(idx[4:3] + 2'd1);
  endfunction

endpackage

// File: rtl/fault_campaign_seq_if.sv
// Bundle of control, injector-drive and result signals around the campaign sequencer.
// The master modport belongs to the test/control side, which also hosts the injector; slave is the sequencer.
interface fault_campaign_seq_if;
  import fault_campaign_seq_pkg::*;

  logic        start;
  logic [3:0]  b_in;
  logic [7:0]  a_in;
  logic [3:0]  inj_b;
  logic [7:0]  inj_a;
  logic [2:0]  inj_loc;
  fault_type_e inj_type;
  logic [7:0]  inj_y;
  logic        busy;
  logic        done;
  logic        err_div0;
  logic [7:0]  golden_y;
  logic [4:0]  det_cnt;
  logic [4:0]  mask_cnt;
  logic [7:0]  det_map;

  modport master (
    output start, b_in, a_in, inj_y,
    input  inj_b, inj_a, inj_loc, inj_type, busy, done, err_div0,
           golden_y, det_cnt, mask_cnt, det_map
  );

  modport slave (
    input  start, b_in, a_in, inj_y,
    output inj_b, inj_a, inj_loc, inj_type, busy, done, err_div0,
           golden_y, det_cnt, mask_cnt, det_map
  );

endinterface

// File: rtl/cfi_golden_seq.sv
// Sequential fault-free reference: 4-cycle shift-add multiply of b*b, then an 8-cycle restoring modulo by a.
// done is high during the final step; rem carries the remainder produced by that step.
module cfi_golden_seq
  import fault_campaign_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [3:0] b,
  input  logic [7:0] a,
  output logic       done,
  output logic [7:0] rem
);

  logic       active;
  logic [3:0] step;
  logic [7:0] acc;     // product during multiply, dividend shifter during modulo
  logic [7:0] mcand;
  logic [3:0] mplier;
  logic [7:0] r;
  logic [7:0] div;

  logic [8:0] r_shift;
  logic [8:0] r_sub;
  logic [7:0] r_next;

  always_comb begin
    r_shift = {r, acc[7]};
    r_sub   = r_shift - {1'b0, div};
    r_next  = (r_shift >= {1'b0, div}) ? r_sub[7:0] : r_shift[7:0];
  end

  assign done = active && (step == 4'(MUL_CYCLES + MOD_CYCLES - 1));
  assign rem  = r_next;

  // NOTE: registers use non-blocking assignments so every term on the right sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active <= 1'b0;
      step   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      r      <= '0;
      div    <= '0;
    end else if (go) begin
      active <= 1'b1;
      step   <= '0;
      acc    <= '0;
      mcand  <= {4'b0, b};
      mplier <= b;
      r      <= '0;
      div    <= a;
    end else if (active) begin
      step <= step + 4'd1;
      if (step < 4'(MUL_CYCLES)) begin
        acc    <= acc + (mplier[0] ? mcand : 8'd0);
        mcand  <= {mcand[6:0], 1'b0};
        mplier <= {1'b0, mplier[3:1]};
      end else begin
        r   <= r_next;
        acc <= {acc[6:0], 1'b0};
      end
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/fault_campaign_seq.sv
// Campaign sequencer: captures operands, obtains the golden Y, sweeps 24 fault injections through
// the combinational injector and tallies detected versus masked faults.
module fault_campaign_seq
  import fault_campaign_seq_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  fault_campaign_seq_if.slave   bus
);

  localparam int CNT_MAX = (SETTLE > MUL_CYCLES) ? SETTLE : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  camp_state_e   state, state_next;
  logic [3:0]    b_q;
  logic [7:0]    a_q;
  logic [4:0]    idx;
  logic [CW-1:0] cnt;
  logic [7:0]    golden_y;
  logic [4:0]    det_cnt;
  logic [4:0]    mask_cnt;
  logic [7:0]    det_map;
  logic          err_div0;

  logic          accept;
  logic          g_go;
  logic          g_done;
  logic [7:0]    g_rem;

  assign accept = (state == IDLE) && bus.start;
  assign g_go   = accept && (bus.a_in != 8'd0);

  cfi_golden_seq u_golden (
    .clk   (clk),
    .reset (reset),
    .go    (g_go),
    .b     (bus.b_in),
    .a     (bus.a_in),
    .done  (g_done),
    .rem   (g_rem)
  );

  // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_next   = state;
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE);
    bus.inj_loc  = 3'd0;
    bus.inj_type = FT_NONE;
    case (state)
      IDLE: if (bus.start) state_next = (bus.a_in == 8'd0) ? DONE : MUL;
      MUL:  if (cnt == CW'(MUL_CYCLES - 1)) state_next = MOD;
      MOD:  if (g_done) state_next = INJ;
      INJ: begin
        bus.inj_loc  = idx[2:0];
        bus.inj_type = ftype_of(idx);
        if (cnt == CW'(SETTLE - 1)) state_next = CMP;
      end
      CMP: begin
        bus.inj_loc  = idx[2:0];
        bus.inj_type = ftype_of(idx);
        state_next   = (idx == 5'(N_INJ - 1)) ? DONE : INJ;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      b_q      <= '0;
      a_q      <= '0;
      idx      <= '0;
      cnt      <= '0;
      golden_y <= '0;
      det_cnt  <= '0;
      mask_cnt <= '0;
      det_map  <= '0;
      err_div0 <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (accept) begin
          b_q      <= bus.b_in;
          a_q      <= bus.a_in;
          idx      <= '0;
          cnt      <= '0;
          golden_y <= '0;
          det_cnt  <= '0;
          mask_cnt <= '0;
          det_map  <= '0;
          err_div0 <= (bus.a_in == 8'd0);
        end
        MUL: cnt <= (state_next == MOD) ? '0 : cnt + CW'(1);
        MOD: begin
          cnt <= '0;
          if (g_done) golden_y <= g_rem;
        end
        INJ: cnt <= cnt + CW'(1);
        CMP: begin
          cnt <= '0;
          idx <= idx + 5'd1;
          if (bus.inj_y != golden_y) begin
            det_cnt           <= det_cnt + 5'd1;
            det_map[idx[2:0]] <= 1'b1;
          end else begin
            mask_cnt <= mask_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inj_b    = b_q;
  assign bus.inj_a    = a_q;
  assign bus.golden_y = golden_y;
  assign bus.det_cnt  = det_cnt;
  assign bus.mask_cnt = mask_cnt;
  assign bus.det_map  = det_map;
  assign bus.err_div0 = err_div0;

endmodule
